// File: rtl/processor_input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module : processor_input_conditioner_pkg
// Brief  : Shared edge encodings and board defaults for the input conditioner.
// Rev    : 1.0
// ============================================================================
package processor_input_conditioner_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } capture_edge_e;

  // 1 ms of stable input at 50 MHz
  localparam int         DEFAULT_DEBOUNCE_CYCLES = 50000;
  // Board buttons are active-low
  localparam logic [3:0] DEFAULT_INVERT_MASK     = 4'hF;

  function automatic logic edge_takes_rise(input capture_edge_e sel);
    return (sel == EDGE_RISE) || (sel == EDGE_BOTH);
  endfunction

  function automatic logic edge_takes_fall(input capture_edge_e sel);
    return (sel == EDGE_FALL) || (sel == EDGE_BOTH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/processor_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module : processor_input_conditioner_if
// Brief  : Board-input / PIO-side signal bundle of the input conditioner.
// Rev    : 1.0
// ============================================================================
interface processor_input_conditioner_if #(
  parameter int WIDTH = 4
) ();
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] capture_clr;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] level_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic [WIDTH-1:0] capture;
  logic             irq;

  modport master (
    output raw_in, capture_clr, irq_mask,
    input  level_out, rise_pulse, fall_pulse, capture, irq
  );

  modport slave (
    input  raw_in, capture_clr, irq_mask,
    output level_out, rise_pulse, fall_pulse, capture, irq
  );
endinterface
`default_nettype wire

// File: rtl/processor_input_conditioner_input_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module : input_debounce_bit
// Brief  : One-bit 2-FF synchroniser, counter debounce and edge pulses.
// Rev    : 1.0
// ============================================================================
module input_debounce_bit
  import processor_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  wire  clk,
  input  wire  reset_n,
  input  wire  cond,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= cond;
      r_s2 <= r_s1;
    end
  end

  // A mismatch must persist for DEBOUNCE_CYCLES samples; any match restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_level <= r_s2;
        r_rise  <= r_s2;
        r_fall  <= ~r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;
endmodule
`default_nettype wire

// File: rtl/processor_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module : processor_input_conditioner
// Brief  : Debounced level bus, edge pulses, sticky capture and IRQ for board inputs.
// Rev    : 1.0
// ============================================================================
module processor_input_conditioner
  import processor_input_conditioner_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [WIDTH-1:0] INVERT_MASK     = WIDTH'(DEFAULT_INVERT_MASK),
  parameter capture_edge_e    CAPTURE_EDGE    = EDGE_RISE
) (
  input wire                              clk,
  input wire                              reset_n,
  processor_input_conditioner_if.slave    bus
);
  localparam logic c_take_rise = edge_takes_rise(CAPTURE_EDGE);
  localparam logic c_take_fall = edge_takes_fall(CAPTURE_EDGE);

  logic [WIDTH-1:0] w_cond;
  logic [WIDTH-1:0] w_level;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] r_capture;

  assign w_cond = bus.raw_in ^ INVERT_MASK;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    input_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .cond    (w_cond[gi]),
      .level   (w_level[gi]),
      .rise    (w_rise[gi]),
      .fall    (w_fall[gi])
    );
  end

  assign w_set = (w_rise & {WIDTH{c_take_rise}}) | (w_fall & {WIDTH{c_take_fall}});

  // A new edge outranks a clear arriving in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_capture <= '0;
    end else begin
      r_capture <= (r_capture & ~bus.capture_clr) | w_set;
    end
  end

  assign bus.level_out  = w_level;
  assign bus.rise_pulse = w_rise;
  assign bus.fall_pulse = w_fall;
  assign bus.capture    = r_capture;
  assign bus.irq        = |(r_capture & bus.irq_mask);
endmodule
`default_nettype wire
